// File: rtl/sudoku_pkg.sv
// Shared types and constants for the 4x4 Sudoku board datapath.
package sudoku_pkg;

  typedef logic [1:0] cell_t;

  typedef enum logic [1:0] {IDLE, LOAD, BLANK, READY} state_t;

  localparam cell_t BASE [4][4] = '{
    '{2'd0, 2'd1, 2'd2, 2'd3},
    '{2'd2, 2'd3, 2'd0, 2'd1},
    '{2'd1, 2'd0, 2'd3, 2'd2},
    '{2'd3, 2'd2, 2'd1, 2'd0}
  };

  // Fibonacci taps 8,6,5,4 -> bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS         = 8'b1011_1000;
  localparam logic [7:0] LFSR_SEED_DEFAULT = 8'hA5;

  localparam logic [3:0] BLANK_CNT [4] = '{4'd4, 4'd6, 4'd8, 4'd10};
  localparam logic [3:0] STRIDE        = 4'd5;

  // Solution digit for cell idx: BASE, optionally transposed, with a symbol relabel.
  function automatic cell_t sol_cell(input logic [7:0] l, input logic [3:0] idx);
    logic [1:0] r, c;
    r = idx[3:2];
    c = idx[1:0];
    return (l[6] ? BASE[c][r] : BASE[r][c]) ^ l[5:4];
  endfunction

endpackage

// File: rtl/sudoku_lfsr.sv
// 8-bit Fibonacci LFSR with hold enable and synchronous active-low reset.
module sudoku_lfsr
  import sudoku_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n)  q <= SEED;
    else if (en) q <= {q[6:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/sudoku_board_dp.sv
// 4x4 Sudoku board datapath: puzzle load, blanking, user commits, display read port.
// Optional saturating error counter built when SUDOKU_ERR_COUNT_EN is defined.
module sudoku_board_dp
  import sudoku_pkg::*;
#(
  parameter logic [7:0]  LFSR_SEED = LFSR_SEED_DEFAULT,
  parameter int unsigned ERR_W     = 4
) (
  input  logic             clka,
  input  logic             restart_n,
  input  logic             gen_rand_flag,
  input  logic             set_board_flag,
  input  logic             set_diff_flag,
  input  logic             row_flag,
  input  logic             col_flag,
  input  logic             val_flag,
  input  logic             check_flag,
  input  logic [1:0]       data_in,
  input  logic [1:0]       rd_row,
  input  logic [1:0]       rd_col,
  output logic [1:0]       rd_val,
  output logic             rd_filled,
  output logic             rd_fixed,
  output logic             solved,
  output logic             busy,
  output logic             wrong,
  output logic [ERR_W-1:0] err_cnt
);

  state_t      state, state_next;
  logic [7:0]  lfsr;
  logic        set_board_d, set_diff_d, board_fall, diff_fall;
  logic [1:0]  diff_r, row_r, col_r;
  cell_t       val_r;
  logic [3:0]  start_r, step_r, blank_idx, blank_last, tgt, rd_idx;
  logic        armed, pending, commit_req, commit_go, we, set_wrong, all_match;
  cell_t       sol   [16];
  cell_t       board [16];
  logic [15:0] filled, fixed;

  sudoku_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clka),
    .rst_n (restart_n),
    .en    (gen_rand_flag),
    .q     (lfsr)
  );

  assign board_fall = set_board_d & ~set_board_flag;
  assign diff_fall  = set_diff_d & ~set_diff_flag;
  assign busy       = (state == LOAD) || (state == BLANK);
  assign blank_last = BLANK_CNT[diff_r] - 4'd1;
  assign blank_idx  = start_r + step_r * STRIDE;
  assign tgt        = {row_r, col_r};
  assign rd_idx     = {rd_row, rd_col};

  assign rd_filled  = filled[rd_idx];
  assign rd_fixed   = fixed[rd_idx];
  assign rd_val     = filled[rd_idx] ? board[rd_idx] : '0;

  // Commits arriving while busy are parked in pending and replayed on READY.
  assign commit_req = check_flag & ~val_flag & armed;
  assign commit_go  = (state == READY) & (commit_req | pending);
  assign set_wrong  = fixed[tgt] | (val_r != sol[tgt]);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (board_fall) state_next = LOAD;
      LOAD:  state_next = READY;
      BLANK: if (board_fall)                state_next = LOAD;
             else if (step_r == blank_last) state_next = READY;
      READY: if (board_fall)      state_next = LOAD;
             else if (diff_fall)  state_next = BLANK;
    endcase
  end

  // solved reflects the board as it will be after this cycle's write.
  always_comb begin
    we        = commit_go && !fixed[tgt];
    all_match = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      if (we && tgt == 4'(i)) begin
        if (val_r != sol[i]) all_match = 1'b0;
      end else if (!filled[i] || board[i] != sol[i]) begin
        all_match = 1'b0;
      end
    end
  end

  always_ff @(posedge clka) begin
    if (!restart_n) begin
      state       <= IDLE;
      set_board_d <= 1'b0;
      set_diff_d  <= 1'b0;
      diff_r      <= '0;
      row_r       <= '0;
      col_r       <= '0;
      val_r       <= '0;
      armed       <= 1'b1;
      pending     <= 1'b0;
    end else begin
      state       <= state_next;
      set_board_d <= set_board_flag;
      set_diff_d  <= set_diff_flag;
      if (set_diff_flag) diff_r <= data_in;
      if (row_flag)      row_r  <= data_in;
      if (col_flag)      col_r  <= data_in;
      if (val_flag)      val_r  <= data_in;
      if (!check_flag)     armed <= 1'b1;
      else if (commit_req) armed <= 1'b0;
      if (state == READY)                  pending <= 1'b0;
      else if (commit_req && busy)         pending <= 1'b1;
    end
  end

  always_ff @(posedge clka) begin
    if (!restart_n) begin
      for (int unsigned i = 0; i < 16; i++) begin
        sol[i]   <= '0;
        board[i] <= '0;
      end
      filled  <= '0;
      fixed   <= '0;
      start_r <= '0;
      step_r  <= '0;
    end else begin
      step_r <= (state == BLANK) ? step_r + 4'd1 : '0;
      if (state == LOAD) begin
        for (int unsigned i = 0; i < 16; i++) begin
          sol[i]   <= sol_cell(lfsr, 4'(i));
          board[i] <= sol_cell(lfsr, 4'(i));
        end
        filled  <= '1;
        fixed   <= '1;
        start_r <= lfsr[3:0];
      end else if (state == BLANK) begin
        filled[blank_idx] <= 1'b0;
        fixed[blank_idx]  <= 1'b0;
      end else if (we) begin
        board[tgt]  <= val_r;
        filled[tgt] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clka) begin
    if (!restart_n || gen_rand_flag) begin
      solved <= 1'b0;
      wrong  <= 1'b0;
    end else if (commit_go) begin
      solved <= all_match;
      wrong  <= set_wrong;
    end
  end

`ifdef SUDOKU_ERR_COUNT_EN
  logic [ERR_W-1:0] err_q;
  always_ff @(posedge clka) begin
    if (!restart_n || gen_rand_flag)            err_q <= '0;
    else if (commit_go && set_wrong && err_q != '1) err_q <= err_q + 1'b1;
  end
  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_sudoku_board_dp.sv
// Self-checking bench for sudoku_board_dp: commit vector table, scoreboard queue, corner sequences.
module tb_sudoku_board_dp;

  localparam logic [7:0] SEED = 8'hA5;

  logic       clka = 1'b0, restart_n = 1'b0;
  logic       gen_rand_flag = 1'b0, set_board_flag = 1'b0, set_diff_flag = 1'b0;
  logic       row_flag = 1'b0, col_flag = 1'b0, val_flag = 1'b0, check_flag = 1'b0;
  logic [1:0] data_in = '0, rd_row = '0, rd_col = '0;
  logic [1:0] rd_val;
  logic       rd_filled, rd_fixed, solved, busy, wrong;
  logic [3:0] err_cnt;

  sudoku_board_dp #(.LFSR_SEED(SEED), .ERR_W(4)) dut (
    .clka           (clka),
    .restart_n      (restart_n),
    .gen_rand_flag  (gen_rand_flag),
    .set_board_flag (set_board_flag),
    .set_diff_flag  (set_diff_flag),
    .row_flag       (row_flag),
    .col_flag       (col_flag),
    .val_flag       (val_flag),
    .check_flag     (check_flag),
    .data_in        (data_in),
    .rd_row         (rd_row),
    .rd_col         (rd_col),
    .rd_val         (rd_val),
    .rd_filled      (rd_filled),
    .rd_fixed       (rd_fixed),
    .solved         (solved),
    .busy           (busy),
    .wrong          (wrong),
    .err_cnt        (err_cnt)
  );

  always #20 clka = ~clka;

  int n_checks = 0, n_fail = 0;

  // reference board model
  logic [7:0] m_lfsr;
  logic [1:0] m_val [16];
  logic [1:0] m_sol [16];
  logic       m_filled [16];
  logic       m_fixed  [16];
  logic [3:0] m_start;
  logic       m_solved;
  int         m_err;

  typedef struct {
    logic       wrong;
    logic       solved;
    logic [3:0] err;
    string      tag;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0] r;
    logic [1:0] c;
    bit         bad;
    int         hold;
    logic       exp_wrong;
  } vec_t;
  vec_t vecs [11];

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // BASE row r is column index XOR bit-reversed r
  function automatic logic [1:0] ref_sol(input logic [7:0] l, input int idx);
    logic [3:0] ix;
    logic [1:0] r, c, t;
    ix = 4'(idx);
    r  = ix[3:2];
    c  = ix[1:0];
    if (l[6]) begin
      t = r; r = c; c = t;
    end
    return c ^ {r[0], r[1]} ^ l[5:4];
  endfunction

  function automatic logic [3:0] exp_err();
`ifdef SUDOKU_ERR_COUNT_EN
    return 4'(m_err);
`else
    return 4'd0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_val[i] = '0; m_sol[i] = '0; m_filled[i] = 1'b0; m_fixed[i] = 1'b0;
    end
    m_err = 0;
  endtask

  task automatic model_load();
    for (int i = 0; i < 16; i++) begin
      m_sol[i] = ref_sol(m_lfsr, i);
      m_val[i] = m_sol[i];
      m_filled[i] = 1'b1;
      m_fixed[i]  = 1'b1;
    end
    m_start = m_lfsr[3:0];
  endtask

  task automatic model_blank(input int n);
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = (int'(m_start) + 5 * k) % 16;
      m_filled[idx] = 1'b0;
      m_fixed[idx]  = 1'b0;
    end
  endtask

  function automatic logic model_commit(input int idx, input logic [1:0] v);
    logic w;
    if (m_fixed[idx]) w = 1'b1;
    else begin
      m_val[idx] = v;
      m_filled[idx] = 1'b1;
      w = (v != m_sol[idx]);
    end
    if (w && m_err < 15) m_err++;
    m_solved = 1'b1;
    for (int i = 0; i < 16; i++)
      if (!m_filled[i] || m_val[i] != m_sol[i]) m_solved = 1'b0;
    return w;
  endfunction

  task automatic check_board(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_row = 2'(i / 4);
      rd_col = 2'(i % 4);
      #1;
      check($sformatf("%s_cell%0d", tag, i), {rd_val, rd_filled, rd_fixed},
            {(m_filled[i] ? m_val[i] : 2'b00), m_filled[i], m_fixed[i]});
    end
  endtask

  task automatic pulse_board(input string tag);
    set_board_flag = 1'b1; tick();
    set_board_flag = 1'b0; tick();
    check({tag, "_busy_on"}, busy, 1);
    tick();
    check({tag, "_busy_off"}, busy, 0);
    model_load();
  endtask

  task automatic start_blank(input logic [1:0] d);
    data_in = d;
    set_diff_flag = 1'b1; tick();
    set_diff_flag = 1'b0; tick();
  endtask

  task automatic wait_not_busy(input string tag, output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      tick();
    end
    if (cycles >= 40) check({tag, "_timeout"}, busy, 0);
  endtask

  task automatic set_entry(input logic [1:0] r, input logic [1:0] c, input logic [1:0] v);
    row_flag = 1'b1; data_in = r; tick();
    row_flag = 1'b0; col_flag = 1'b1; data_in = c; tick();
    col_flag = 1'b0; val_flag = 1'b1; data_in = v; tick();
    val_flag = 1'b0;
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    check({e.tag, "_wrong"},  wrong,   e.wrong);
    check({e.tag, "_solved"}, solved,  e.solved);
    check({e.tag, "_err"},    err_cnt, e.err);
  endtask

  task automatic do_commit(input vec_t v, input int n);
    int idx;
    logic [1:0] val;
    idx = int'(v.r) * 4 + int'(v.c);
    val = v.bad ? m_sol[idx] + 2'd1 : m_sol[idx];
    set_entry(v.r, v.c, val);
    void'(model_commit(idx, val));
    sb.push_back('{v.exp_wrong, m_solved, exp_err(), $sformatf("vec%0d", n)});
    check_flag = 1'b1;
    tick();
    pop_check();
    rd_row = v.r; rd_col = v.c;
    #1;
    check($sformatf("vec%0d_cell", n), {rd_val, rd_filled}, {m_val[idx], m_filled[idx]});
    for (int h = 1; h < v.hold; h++) tick();
    if (v.hold > 1) check($sformatf("vec%0d_rearm_err", n), err_cnt, exp_err());
    check_flag = 1'b0;
    tick();
  endtask

  initial begin
    int n, cyc, idx;
    logic [7:0] l;
    logic [1:0] val, r, c;
    logic w;

    vecs[0]  = '{2'd0, 2'd0, 1'b1, 3, 1'b1};
    vecs[1]  = '{2'd0, 2'd1, 1'b0, 1, 1'b1};
    vecs[2]  = '{2'd0, 2'd0, 1'b0, 1, 1'b0};
    vecs[3]  = '{2'd1, 2'd1, 1'b0, 1, 1'b0};
    vecs[4]  = '{2'd2, 2'd2, 1'b1, 1, 1'b1};
    vecs[5]  = '{2'd2, 2'd2, 1'b0, 1, 1'b0};
    vecs[6]  = '{2'd3, 2'd3, 1'b0, 1, 1'b0};
    vecs[7]  = '{2'd1, 2'd0, 1'b0, 1, 1'b0};
    vecs[8]  = '{2'd2, 2'd1, 1'b0, 1, 1'b0};
    vecs[9]  = '{2'd3, 2'd2, 1'b0, 1, 1'b0};
    vecs[10] = '{2'd0, 2'd3, 1'b0, 1, 1'b0};

    restart_n = 1'b0;
    tick(); tick();
    model_reset();
    check("rst_busy", busy, 0);
    check("rst_solved", solved, 0);
    check("rst_wrong", wrong, 0);
    check("rst_err", err_cnt, 0);
    check_board("rst");
    restart_n = 1'b1;
    tick();

    m_lfsr = SEED;
    pulse_board("load_seed");
    check("load_seed_solved", solved, 0);
    check_board("load_seed");

    // advance the LFSR until the blanking start index is 0
    l = SEED; n = 0;
    while (l[3:0] != 4'd0 && n < 255) begin
      l = lfsr_next(l);
      n++;
    end
    gen_rand_flag = 1'b1;
    repeat (n) tick();
    gen_rand_flag = 1'b0;
    m_lfsr = l;
    pulse_board("load2");
    check_board("load2");

    start_blank(2'd2);
    wait_not_busy("blank8", cyc);
    check("blank8_len", cyc, 8);
    model_blank(8);
    check_board("blank8");

    for (int i = 0; i < 11; i++) do_commit(vecs[i], i);
    check_board("solved_board");

    gen_rand_flag = 1'b1;
    tick();
    gen_rand_flag = 1'b0;
    m_lfsr = lfsr_next(m_lfsr);
    m_err = 0;
    check("genrand_solved", solved, 0);
    check("genrand_wrong", wrong, 0);
    check("genrand_err", err_cnt, 0);

    // commit raised during BLANK is held until READY
    pulse_board("load3");
    idx = int'(m_start);
    r = 2'(idx / 4);
    c = 2'(idx % 4);
    val = m_sol[idx] + 2'd1;
    set_entry(r, c, val);
    start_blank(2'd0);
    check("blank4_busy", busy, 1);
    model_blank(4);
    w = model_commit(idx, val);
    sb.push_back('{w, m_solved, exp_err(), "pending"});
    check_flag = 1'b1;
    tick();
    check_flag = 1'b0;
    wait_not_busy("blank4", cyc);
    check("blank4_len", cyc, 3);
    check("pending_not_yet", wrong, 0);
    tick();
    pop_check();
    check_board("pending");

    // set_board fall mid-BLANK reloads a full board
    start_blank(2'd3);
    tick(); tick();
    pulse_board("abort");
    check_board("abort");

    start_blank(2'd1);
    tick();
    restart_n = 1'b0;
    tick();
    model_reset();
    check("midrst_busy", busy, 0);
    check("midrst_wrong", wrong, 0);
    check_board("midrst");
    restart_n = 1'b1;

    // commit before any load is ignored
    set_entry(2'd0, 2'd0, 2'd1);
    check_flag = 1'b1;
    tick();
    check("idle_commit_wrong", wrong, 0);
    check_flag = 1'b0;
    tick();
    check_board("idle_commit");

    m_lfsr = SEED;
    pulse_board("reload_seed");
    check_board("reload_seed");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
